// File: rtl/uart_tx_sched.sv
// Two-channel frame scheduler for a shared UART transmitter: round-robin grant,
// per-frame tick timeout, and an idle gap of baud ticks between frames.
module uart_tx_sched #(
    parameter int GAP_TICKS     = 2,
    parameter int TIMEOUT_TICKS = 16
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic [3:0] cfg0,
    input  logic [3:0] cfg1,
    output logic       ack0,
    output logic       ack1,
    output logic       done0,
    output logic       done1,
    output logic       send,
    output logic [7:0] tx_data,
    output logic       stop_bits,
    output logic       data_length,
    output logic [1:0] parity_type,
    input  logic       tx_active,
    input  logic       tx_done,
    output logic       busy,
    output logic       owner,
    output logic       timeout_err,
    output logic [1:0] state_o
);

    // Handshake: reqN is a level held until ackN; ackN is a one-cycle pulse on the
    // cycle after the grant edge, and the captured data/cfg stays frozen until IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_TICKS);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_TICKS - 1);

    state_t        state_q, state_d;
    logic [7:0]    data_q, data_d;
    logic [3:0]    cfg_q, cfg_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          ack0_q, ack0_d, ack1_q, ack1_d;
    logic          done0_q, done0_d, done1_q, done1_d;
    logic          terr_q, terr_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [TW-1:0] tick_q, tick_d;

    logic       grant_ch;
    logic [7:0] sel_data;
    logic [3:0] sel_cfg;

    // With both requesting, the channel that did not go last wins.
    assign grant_ch = (req0 && req1) ? ~last_q : req1;
    assign sel_data = grant_ch ? data1 : data0;
    assign sel_cfg  = grant_ch ? cfg1 : cfg0;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cfg_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            terr_q  <= 1'b0;
            gap_q   <= '0;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cfg_q   <= cfg_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            terr_q  <= terr_d;
            gap_q   <= gap_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cfg_d   = cfg_q;
        owner_d = owner_q;
        last_d  = last_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        terr_d  = terr_q;
        gap_d   = gap_q;
        tick_d  = tick_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d = grant_ch;
                    last_d  = grant_ch;
                    data_d  = sel_data;
                    if (!sel_cfg[2]) data_d[7] = 1'b0;
                    cfg_d   = sel_cfg;
                    ack0_d  = ~grant_ch;
                    ack1_d  = grant_ch;
                    tick_d  = '0;
                    state_d = SEND;
                end
            end
            SEND, WAIT: begin
                // A completion in the same cycle as the final tick still counts as done.
                if (tx_done) begin
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                    gap_d   = GAP_LOAD;
                    state_d = GAP;
                end else if (baud_tick && tick_q == TO_LAST) begin
                    terr_d  = 1'b1;
                    gap_d   = GAP_LOAD;
                    state_d = GAP;
                end else begin
                    if (baud_tick) tick_d = tick_q + 1'b1;
                    if (state_q == SEND && tx_active) state_d = WAIT;
                end
            end
            GAP: begin
                if (gap_q == '0) state_d = IDLE;
                else if (baud_tick) gap_d = gap_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign done0       = done0_q;
    assign done1       = done1_q;
    assign send        = (state_q == SEND) || (state_q == WAIT);
    assign tx_data     = data_q;
    assign stop_bits   = cfg_q[3];
    assign data_length = cfg_q[2];
    assign parity_type = cfg_q[1:0];
    assign busy        = (state_q != IDLE);
    assign owner       = owner_q;
    assign timeout_err = terr_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: a grant scoreboard fed at request time and
// drained on ack, plus step-by-step checks of frame, gap, timeout and reset behaviour.
module tb_uart_tx_sched;

    logic       clock = 1'b0;
    logic       rst;
    logic       baud_tick;
    logic       req0, req1;
    logic [7:0] data0, data1;
    logic [3:0] cfg0, cfg1;
    logic       tx_active, tx_done;
    logic       ack0, ack1, done0, done1, send;
    logic [7:0] tx_data;
    logic       stop_bits, data_length;
    logic [1:0] parity_type;
    logic       busy, owner, timeout_err;
    logic [1:0] state_o;

    // Second instance with no inter-frame gap; own request/done inputs.
    logic       req0_b, req1_b, tx_done_b;
    logic       ack0_b, ack1_b, done0_b, done1_b, send_b;
    logic [7:0] tx_data_b;
    logic       stop_bits_b, data_length_b;
    logic [1:0] parity_type_b;
    logic       busy_b, owner_b, timeout_err_b;
    logic [1:0] state_b;

    logic [12:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_cnt = 0;

    always #5 clock = ~clock;

    uart_tx_sched u_dut (
        .clock(clock), .rst(rst), .baud_tick(baud_tick),
        .req0(req0), .req1(req1), .data0(data0), .data1(data1),
        .cfg0(cfg0), .cfg1(cfg1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
        .send(send), .tx_data(tx_data), .stop_bits(stop_bits),
        .data_length(data_length), .parity_type(parity_type),
        .tx_active(tx_active), .tx_done(tx_done),
        .busy(busy), .owner(owner), .timeout_err(timeout_err), .state_o(state_o)
    );

    uart_tx_sched #(.GAP_TICKS(0)) u_gap0 (
        .clock(clock), .rst(rst), .baud_tick(baud_tick),
        .req0(req0_b), .req1(req1_b), .data0(data0), .data1(data1),
        .cfg0(cfg0), .cfg1(cfg1),
        .ack0(ack0_b), .ack1(ack1_b), .done0(done0_b), .done1(done1_b),
        .send(send_b), .tx_data(tx_data_b), .stop_bits(stop_bits_b),
        .data_length(data_length_b), .parity_type(parity_type_b),
        .tx_active(tx_active), .tx_done(tx_done_b),
        .busy(busy_b), .owner(owner_b), .timeout_err(timeout_err_b), .state_o(state_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] exp_frame(input logic ch, input logic [7:0] d, input logic [3:0] c);
        logic [7:0] dd;
        dd = d;
        if (c[2] == 1'b0) dd[7] = 1'b0;
        return {ch, dd, c[3], c[2], c[1:0]};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic baud();
        baud_tick = 1'b1;
        tick();
        baud_tick = 1'b0;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_ack();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(ack0 || ack1) && n < 20);
        check("ack_seen", 32'(ack0 | ack1), 1);
    endtask

    task automatic finish_frame(input logic ch);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("done_owner", 32'({done1, done0}), ch ? 2 : 1);
        check("send_dropped", 32'(send), 0);
        check("state_gap", 32'(state_o), 3);
        tick();
        baud();
        baud();
        tick();
        check("state_idle", 32'(state_o), 0);
        check("busy_idle", 32'(busy), 0);
    endtask

    // Scoreboard drain and mutual-exclusion checks on ack/done.
    always @(negedge clock) begin
        logic [12:0] e;
        if (!rst) begin
            if (ack0 || ack1) begin
                check("ack_excl", 32'(ack0 & ack1), 0);
                if (exp_q.size() == 0) begin
                    check("sb_empty_on_ack", 32'(exp_q.size()), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_fields", 32'({owner, tx_data, stop_bits, data_length, parity_type}), 32'(e));
                end
            end
            if (done0 || done1) begin
                check("done_excl", 32'(done0 & done1), 0);
                done_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int cyc;
        rst = 1'b1; baud_tick = 1'b0;
        req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0; cfg0 = '0; cfg1 = '0;
        tx_active = 1'b0; tx_done = 1'b0;
        req0_b = 1'b0; req1_b = 1'b0; tx_done_b = 1'b0;
        tick();
        tick();
        check("rst_send", 32'(send), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_outs", 32'({ack0, ack1, done0, done1, owner, timeout_err}), 0);
        check("rst_cfg", 32'({tx_data, stop_bits, data_length, parity_type}), 0);
        check("rst_state", 32'(state_o), 0);
        rst = 1'b0;
        tick();

        // Single frame on channel 0.
        req0 = 1'b1; data0 = 8'hA5; cfg0 = 4'b0100;
        exp_q.push_back(exp_frame(1'b0, 8'hA5, 4'b0100));
        wait_ack();
        req0 = 1'b0;
        check("f1_ack0", 32'(ack0), 1);
        check("f1_send", 32'(send), 1);
        check("f1_busy", 32'(busy), 1);
        check("f1_tx_data", 32'(tx_data), 'hA5);
        tx_active = 1'b1;
        tick();
        check("f1_wait", 32'(state_o), 2);
        check("f1_ack_pulse", 32'(ack0), 0);
        baud();
        baud();
        check("f1_send_wait", 32'(send), 1);
        tx_active = 1'b0;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("f1_done0", 32'(done0), 1);
        check("f1_send_low", 32'(send), 0);
        tick();
        check("f1_done_pulse", 32'(done0), 0);
        baud();
        baud();
        check("f1_gap_hold", 32'(state_o), 3);
        tick();
        check("f1_idle", 32'(state_o), 0);

        // Both channels held after reset: grants alternate 0,1,0,1.
        reset_pulse();
        req0 = 1'b1; req1 = 1'b1; data0 = 8'h11; data1 = 8'h22; cfg0 = 4'b0100; cfg1 = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(exp_frame(k[0], k[0] ? 8'h22 : 8'h11, 4'b0100));
            wait_ack();
            check("rr_owner", 32'(owner), 32'(k[0]));
            if (k == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            finish_frame(k[0]);
        end

        // Channel 1, 7-bit data: MSB forced low; captured fields frozen.
        req1 = 1'b1; data1 = 8'hFF; cfg1 = 4'b1001;
        exp_q.push_back(exp_frame(1'b1, 8'hFF, 4'b1001));
        wait_ack();
        req1 = 1'b0;
        check("c1_tx_data", 32'(tx_data), 'h7F);
        check("c1_cfg", 32'({stop_bits, data_length, parity_type}), 'b1001);
        data1 = 8'h00; cfg1 = 4'b0110;
        tick();
        check("c1_stable_data", 32'(tx_data), 'h7F);
        check("c1_stable_cfg", 32'({stop_bits, data_length, parity_type}), 'b1001);
        finish_frame(1'b1);

        // No tx_done: abort after exactly 16 baud ticks.
        req0 = 1'b1; data0 = 8'h3C; cfg0 = 4'b0000;
        exp_q.push_back(exp_frame(1'b0, 8'h3C, 4'b0000));
        wait_ack();
        req0 = 1'b0;
        tx_active = 1'b1;
        tick();
        d0 = done_cnt;
        for (int i = 0; i < 15; i++) baud();
        check("to_send_before", 32'(send), 1);
        check("to_err_before", 32'(timeout_err), 0);
        baud();
        check("to_send_after", 32'(send), 0);
        check("to_err_after", 32'(timeout_err), 1);
        check("to_state_gap", 32'(state_o), 3);
        tick();
        baud();
        baud();
        tick();
        tx_active = 1'b0;
        check("to_idle", 32'(state_o), 0);
        check("to_no_done", 32'(done_cnt), 32'(d0));
        req1 = 1'b1; data1 = 8'h5A; cfg1 = 4'b0100;
        exp_q.push_back(exp_frame(1'b1, 8'h5A, 4'b0100));
        wait_ack();
        req1 = 1'b0;
        finish_frame(1'b1);
        check("to_err_sticky", 32'(timeout_err), 1);

        // Reset during WAIT: outputs clear at once, no done, clean re-grant.
        req0 = 1'b1; data0 = 8'h81; cfg0 = 4'b0110;
        exp_q.push_back(exp_frame(1'b0, 8'h81, 4'b0110));
        wait_ack();
        req0 = 1'b0;
        tx_active = 1'b1;
        tick();
        check("rw_wait", 32'(state_o), 2);
        d0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        check("rw_send", 32'(send), 0);
        check("rw_busy", 32'(busy), 0);
        check("rw_outs", 32'({ack0, ack1, done0, done1, owner, timeout_err}), 0);
        check("rw_cfg", 32'({tx_data, stop_bits, data_length, parity_type}), 0);
        @(posedge clock);
        #1;
        rst = 1'b0;
        tx_active = 1'b0;
        tick();
        check("rw_no_done", 32'(done_cnt), 32'(d0));
        req0 = 1'b1; req1 = 1'b1; data0 = 8'h42; cfg0 = 4'b0100;
        exp_q.push_back(exp_frame(1'b0, 8'h42, 4'b0100));
        wait_ack();
        req0 = 1'b0;
        req1 = 1'b0;
        check("rw_owner0", 32'(owner), 0);
        finish_frame(1'b0);

        // Zero-gap instance: back-to-back frame starts within 2 clocks of done.
        data0 = 8'h99; cfg0 = 4'b0100;
        req0_b = 1'b1;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!ack0_b && cyc < 20);
        check("g0_ack", 32'(ack0_b), 1);
        tx_done_b = 1'b1;
        tick();
        tx_done_b = 1'b0;
        check("g0_done0", 32'(done0_b), 1);
        cyc = 0;
        while (!send_b && cyc < 10) begin
            tick();
            cyc++;
        end
        check("g0_restart_le2", 32'(cyc >= 1 && cyc <= 2), 1);
        check("g0_ack_again", 32'(ack0_b), 1);
        req0_b = 1'b0;
        tx_done_b = 1'b1;
        tick();
        tx_done_b = 1'b0;
        tick();
        tick();
        check("g0_idle", 32'(state_b), 0);

        check("sb_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
